// File: rtl/mvm_pkg.sv
// Shared types and width helpers for the 3x3 matrix-vector multiplier.
// The controller and its bus interface import this package.
package mvm_pkg;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_X,
        MAC,
        OUT
    } state_t;

    localparam int N_DEFAULT = 3;

    // A width of 1 is kept for degenerate sizes so no bus ever collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int aw_a(input int n);
        return clog2_min1(n * n);
    endfunction

    function automatic int aw_x(input int n);
        return clog2_min1(n);
    endfunction

    function automatic int kw(input int n);
        return clog2_min1(n + 1);
    endfunction

endpackage

// File: rtl/mvm3_ctrl_if.sv
// Control bus between mvm3_ctrl and the stream ports / memory-MAC datapath.
// The master side is the controller, the slave side is everything around it.
interface mvm3_ctrl_if import mvm_pkg::*; #(
    parameter int N = N_DEFAULT
) ();

    logic                 s_valid;
    logic                 s_ready;
    logic                 m_valid;
    logic                 m_ready;
    logic                 wr_en_a;
    logic                 wr_en_x;
    logic [aw_a(N)-1:0]   addr_a;
    logic [aw_x(N)-1:0]   addr_x;
    logic                 clear_acc;
    logic                 en_acc;

    modport master (
        input  s_valid,
        input  m_ready,
        output s_ready,
        output m_valid,
        output wr_en_a,
        output wr_en_x,
        output addr_a,
        output addr_x,
        output clear_acc,
        output en_acc
    );

    modport slave (
        output s_valid,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  wr_en_a,
        input  wr_en_x,
        input  addr_a,
        input  addr_x,
        input  clear_acc,
        input  en_acc
    );

endinterface

// File: rtl/mvm3_ctrl.sv
// Control FSM for the NxN matrix-vector multiplier: loads A then x, steps the MAC
// through each row and hands every y[r] downstream over valid/ready.
module mvm3_ctrl import mvm_pkg::*; #(
    parameter int N = N_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    mvm3_ctrl_if.master   bus
);

    localparam int AW_A = aw_a(N);
    localparam int AW_X = aw_x(N);
    localparam int KW   = kw(N);

    localparam logic [AW_A-1:0] LD_LAST_A = AW_A'(N * N - 1);
    localparam logic [AW_A-1:0] LD_LAST_X = AW_A'(N - 1);
    localparam logic [KW-1:0]   K_LAST    = KW'(N);
    localparam logic [KW-1:0]   K_HOLD    = KW'(N - 1);
    localparam logic [AW_X-1:0] R_LAST    = AW_X'(N - 1);

    state_t            state;
    state_t            state_nxt;
    logic [AW_A-1:0]   ld_cnt;
    logic [KW-1:0]     k;
    logic [AW_X-1:0]   r;
    logic              en_d;
    logic              clr_d;
    logic              accept;
    logic [KW-1:0]     k_eff;
    logic [AW_A-1:0]   mac_addr_a;

    assign accept = bus.s_valid && bus.s_ready;

    // The k==N step and OUT keep presenting the last issued column so addresses stay put.
    assign k_eff      = (k == K_LAST) ? K_HOLD : k;
    assign mac_addr_a = AW_A'(int'(r) * N + int'(k_eff));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= LOAD_A;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD_A: if (accept && ld_cnt == LD_LAST_A) state_nxt = LOAD_X;
            LOAD_X: if (accept && ld_cnt == LD_LAST_X) state_nxt = MAC;
            MAC:    if (k == K_LAST) state_nxt = OUT;
            OUT:    if (bus.m_ready) state_nxt = (r == R_LAST) ? LOAD_A : MAC;
            default: state_nxt = LOAD_A;
        endcase
    end

    // s_ready is gated by reset_n so nothing can be written while reset is held.
    always_comb begin
        bus.s_ready   = 1'b0;
        bus.m_valid   = 1'b0;
        bus.wr_en_a   = 1'b0;
        bus.wr_en_x   = 1'b0;
        bus.addr_a    = '0;
        bus.addr_x    = '0;
        bus.en_acc    = en_d;
        bus.clear_acc = clr_d;
        case (state)
            LOAD_A: begin
                bus.s_ready = reset_n;
                bus.wr_en_a = reset_n && bus.s_valid;
                bus.addr_a  = ld_cnt;
            end
            LOAD_X: begin
                bus.s_ready = reset_n;
                bus.wr_en_x = reset_n && bus.s_valid;
                bus.addr_x  = ld_cnt[AW_X-1:0];
            end
            MAC: begin
                bus.addr_a = mac_addr_a;
                bus.addr_x = AW_X'(k_eff);
            end
            OUT: begin
                bus.m_valid = 1'b1;
                bus.addr_a  = mac_addr_a;
                bus.addr_x  = AW_X'(k_eff);
            end
            default: ;
        endcase
    end

    // en/clear trail the address by one cycle to line up with the synchronous memory read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ld_cnt <= '0;
            k      <= '0;
            r      <= '0;
            en_d   <= 1'b0;
            clr_d  <= 1'b0;
        end else begin
            en_d  <= (state == MAC) && (k != K_LAST);
            clr_d <= (state == MAC) && (k == '0);
            case (state)
                LOAD_A: begin
                    if (accept) ld_cnt <= (ld_cnt == LD_LAST_A) ? '0 : ld_cnt + AW_A'(1);
                end
                LOAD_X: begin
                    if (accept) begin
                        if (ld_cnt == LD_LAST_X) begin
                            ld_cnt <= '0;
                            r      <= '0;
                            k      <= '0;
                        end else begin
                            ld_cnt <= ld_cnt + AW_A'(1);
                        end
                    end
                end
                MAC: begin
                    if (k != K_LAST) k <= k + KW'(1);
                end
                OUT: begin
                    if (bus.m_ready) begin
                        k <= '0;
                        if (r == R_LAST) begin
                            r      <= '0;
                            ld_cnt <= '0;
                        end else begin
                            r <= r + AW_X'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mvm3_ctrl.sv
// Bench for mvm3_ctrl: a behavioural memory/MAC datapath turns the control outputs
// into y values, which are scored against software dot products.
module tb_mvm3_ctrl;
    import mvm_pkg::*;

    localparam int N = 3;

    typedef struct {
        logic s_valid;
        logic m_ready;
        logic exp_s_ready;
        logic exp_m_valid;
        logic exp_en;
        logic exp_clr;
        logic exp_wr;
        int   exp_addr_a;
        int   exp_addr_x;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] data_in = '0;

    mvm3_ctrl_if #(.N(N)) bus ();

    mvm3_ctrl #(.N(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem_a [N*N];
    logic [15:0] mem_x [N];
    logic [15:0] rd_a;
    logic [15:0] rd_x;
    logic [31:0] acc;

    always @(posedge clk) begin
        if (bus.wr_en_a) mem_a[bus.addr_a] <= data_in;
        if (bus.wr_en_x) mem_x[bus.addr_x] <= data_in;
        rd_a <= mem_a[bus.addr_a];
        rd_x <= mem_x[bus.addr_x];
        if (bus.en_acc) acc <= bus.clear_acc ? 32'(rd_a) * 32'(rd_x) : acc + 32'(rd_a) * 32'(rd_x);
    end

    int checks = 0;
    int errors = 0;
    int wr_a_cnt = 0;
    int wr_x_cnt = 0;
    int hs_cnt = 0;
    int wr_a_log[$];
    int wr_x_log[$];
    int exp_q[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Sampled mid-cycle: anything seen here transfers on the following posedge.
    always begin
        @(negedge clk);
        #2;
        if (!bus.s_valid) checkOutput("wr_en_idle", {30'b0, bus.wr_en_a, bus.wr_en_x}, 32'd0);
        if (bus.wr_en_a) begin
            wr_a_cnt++;
            wr_a_log.push_back(int'(bus.addr_a));
        end
        if (bus.wr_en_x) begin
            wr_x_cnt++;
            wr_x_log.push_back(int'(bus.addr_x));
        end
        if (bus.m_valid && bus.m_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL y_unexpected: got %0d expected none at %0t", acc, $time);
            end else begin
                checkOutput("y", acc, exp_q.pop_front());
            end
        end
    end

    task automatic applyStimulus(input int a[N*N], input int x[N], input int gap_pct);
        int idx;
        int budget;
        for (int rr = 0; rr < N; rr++) begin
            int y = 0;
            for (int c = 0; c < N; c++) y += a[rr*N+c] * x[c];
            exp_q.push_back(y);
        end
        idx = 0;
        budget = 0;
        while (idx < N*N + N && budget < 500) begin
            @(negedge clk);
            budget++;
            bus.s_valid = ($urandom_range(99) >= gap_pct);
            data_in = 16'((idx < N*N) ? a[idx] : x[idx - N*N]);
            #1;
            checkOutput("s_ready_load", bus.s_ready, 1);
            if (idx < N*N) begin
                checkOutput("wr_en_a", bus.wr_en_a, bus.s_valid);
                checkOutput("addr_a_load", bus.addr_a, idx);
            end else begin
                checkOutput("wr_en_x", bus.wr_en_x, bus.s_valid);
                checkOutput("addr_x_load", bus.addr_x, idx - N*N);
            end
            if (bus.s_valid) idx++;
        end
        if (idx < N*N + N) checkOutput("load_timeout", idx, N*N + N);
    endtask

    task automatic drainOutputs(input int mr_pct, input int budget);
        int start = hs_cnt;
        int cyc = 0;
        while (hs_cnt < start + N && cyc < budget) begin
            @(negedge clk);
            cyc++;
            bus.s_valid = 1'b0;
            bus.m_ready = ($urandom_range(99) >= mr_pct);
            #3;
        end
        checkOutput("drain_handshakes", hs_cnt - start, N);
        @(posedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_s_ready"}, bus.s_ready, 0);
        checkOutput({tag, "_m_valid"}, bus.m_valid, 0);
        checkOutput({tag, "_wr_en_a"}, bus.wr_en_a, 0);
        checkOutput({tag, "_wr_en_x"}, bus.wr_en_x, 0);
        checkOutput({tag, "_en_acc"}, bus.en_acc, 0);
        checkOutput({tag, "_clear_acc"}, bus.clear_acc, 0);
        checkOutput({tag, "_addr_a"}, bus.addr_a, 0);
        checkOutput({tag, "_addr_x"}, bus.addr_x, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[15];
        int a_seq[N*N];
        int x_seq[N];
        int a_one[N*N];
        int x_two[N];
        int a_rnd[N*N];
        int x_rnd[N];
        int cyc;

        // Expected MAC/OUT trace for one product, m_ready held high throughout.
        for (int rr = 0; rr < N; rr++) begin
            for (int kk = 0; kk <= N + 1; kk++) begin
                vecs[rr*(N+2)+kk] = '{(rr == 0 && kk == 0), 1'b1, 1'b0, (kk == N + 1),
                                      (kk >= 1 && kk <= N), (kk == 1), 1'b0,
                                      rr*N + ((kk < N) ? kk : N - 1), (kk < N) ? kk : N - 1};
            end
        end
        for (int i = 0; i < N*N; i++) begin
            a_seq[i] = i + 1;
            a_one[i] = 1;
        end
        for (int i = 0; i < N; i++) begin
            x_seq[i] = i + 1;
            x_two[i] = 2;
        end

        bus.s_valid = 1'b1;
        bus.m_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        reset_n = 1'b1;

        $display("[TB] directed product A=1..9 x=1,2,3");
        applyStimulus(a_seq, x_seq, 0);
        foreach (vecs[i]) begin
            @(negedge clk);
            bus.s_valid = vecs[i].s_valid;
            bus.m_ready = vecs[i].m_ready;
            #1;
            checkOutput($sformatf("vec%0d_s_ready", i), bus.s_ready, vecs[i].exp_s_ready);
            checkOutput($sformatf("vec%0d_m_valid", i), bus.m_valid, vecs[i].exp_m_valid);
            checkOutput($sformatf("vec%0d_en_acc", i), bus.en_acc, vecs[i].exp_en);
            checkOutput($sformatf("vec%0d_clear_acc", i), bus.clear_acc, vecs[i].exp_clr);
            checkOutput($sformatf("vec%0d_wr_en", i), bus.wr_en_a | bus.wr_en_x, vecs[i].exp_wr);
            checkOutput($sformatf("vec%0d_addr_a", i), bus.addr_a, vecs[i].exp_addr_a);
            checkOutput($sformatf("vec%0d_addr_x", i), bus.addr_x, vecs[i].exp_addr_x);
        end

        $display("[TB] back-to-back product of ones with x=2,2,2");
        applyStimulus(a_one, x_two, 0);
        drainOutputs(0, 100);

        $display("[TB] random valid/ready gaps");
        wr_a_cnt = 0;
        wr_x_cnt = 0;
        wr_a_log.delete();
        wr_x_log.delete();
        for (int i = 0; i < N*N; i++) a_rnd[i] = $urandom_range(15);
        for (int i = 0; i < N; i++) x_rnd[i] = $urandom_range(15);
        applyStimulus(a_rnd, x_rnd, 50);
        drainOutputs(50, 400);
        checkOutput("wr_a_pulses", wr_a_cnt, N*N);
        checkOutput("wr_x_pulses", wr_x_cnt, N);
        if (wr_a_log.size() == N*N)
            for (int i = 0; i < N*N; i++) checkOutput("wr_a_order", wr_a_log[i], i);
        if (wr_x_log.size() == N)
            for (int i = 0; i < N; i++) checkOutput("wr_x_order", wr_x_log[i], i);

        $display("[TB] back-pressure in OUT");
        for (int i = 0; i < N*N; i++) a_rnd[i] = $urandom_range(15);
        applyStimulus(a_rnd, x_rnd, 0);
        cyc = 0;
        do begin
            @(negedge clk);
            bus.s_valid = 1'b0;
            bus.m_ready = 1'b0;
            cyc++;
            #1;
        end while (!bus.m_valid && cyc < 10);
        checkOutput("out_latency", cyc, N + 2);
        repeat (20) begin
            @(negedge clk);
            #1;
            checkOutput("bp_m_valid", bus.m_valid, 1);
            checkOutput("bp_s_ready", bus.s_ready, 0);
            checkOutput("bp_en_acc", bus.en_acc, 0);
            checkOutput("bp_addr_a", bus.addr_a, N - 1);
            checkOutput("bp_addr_x", bus.addr_x, N - 1);
        end
        drainOutputs(0, 100);

        $display("[TB] reset during row 1 MAC");
        applyStimulus(a_rnd, x_rnd, 0);
        for (int c = 1; c <= 2*(N+2) - 2; c++) begin
            @(negedge clk);
            bus.s_valid = 1'b0;
            bus.m_ready = 1'b1;
        end
        #1;
        checkOutput("pre_reset_addr_a", bus.addr_a, N + 2);
        checkOutput("pre_reset_en_acc", bus.en_acc, 1);
        #1;
        reset_n = 1'b0;
        #1;
        checkResetOutputs("async_reset");
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < N*N; i++) a_rnd[i] = $urandom_range(15);
        for (int i = 0; i < N; i++) x_rnd[i] = $urandom_range(15);
        applyStimulus(a_rnd, x_rnd, 0);
        drainOutputs(0, 100);
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
